// File: rtl/pong_pkg.sv
// Shared types, screen geometry and paddle motion helper for the Pong engine.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_POINT,
      ST_OVER
   } state_t;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // Frame tick sits at the first column of the first blanking line.
   localparam int TICK_X = 0;
   localparam int TICK_Y = 480;

   // One frame of paddle motion: opposing or absent buttons hold, result clamped on screen.
   function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up,
                                              input logic dn, input int speed,
                                              input int height);
      logic [10:0] ext;
      logic [10:0] spd;
      logic [10:0] lim;
      ext = {1'b0, y};
      spd = 11'(speed);
      lim = 11'(V_ACTIVE - height);
      paddle_step = y;
      if (up && !dn) begin
         paddle_step = (ext < spd) ? 10'd0 : 10'(ext - spd);
      end else if (dn && !up) begin
         paddle_step = (ext + spd > lim) ? 10'(lim) : 10'(ext + spd);
      end
   endfunction

endpackage

// File: rtl/pong_ball.sv
// Ball position/velocity registers with wall bounce, paddle reflection and miss detection.
module pong_ball
   import pong_pkg::*;
#(
   parameter int PADDLE_H   = 64,
   parameter int PADDLE_W   = 8,
   parameter int BALL_SZ    = 8,
   parameter int LEFT_X     = 16,
   parameter int RIGHT_X    = 616,
   parameter int BALL_SPEED = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move,
   input  logic       centre,
   input  logic [9:0] pad_l,
   input  logic [9:0] pad_r,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       miss_l,
   output logic       miss_r
);

   localparam logic [9:0]         CX     = 10'(H_ACTIVE / 2 - BALL_SZ / 2);
   localparam logic [9:0]         CY     = 10'(V_ACTIVE / 2 - BALL_SZ / 2);
   localparam logic signed [10:0] SPD    = 11'(BALL_SPEED);
   localparam logic signed [10:0] SZ     = 11'(BALL_SZ);
   localparam logic signed [10:0] PH     = 11'(PADDLE_H);
   localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SZ);
   localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SZ);
   localparam logic signed [10:0] L_FACE = 11'(LEFT_X + PADDLE_W);
   localparam logic signed [10:0] L_BACK = 11'(LEFT_X);
   localparam logic signed [10:0] R_FACE = 11'(RIGHT_X);
   localparam logic signed [10:0] R_BACK = 11'(RIGHT_X + PADDLE_W);

   logic [9:0]         x_reg, y_reg, x_next, y_next;
   logic               vx_neg_reg, vy_neg_reg, vx_neg_next, vy_neg_next;
   logic signed [10:0] bx, by, nx, ny, pl, pr;
   logic               ovl_l, ovl_r, hit_l, hit_r, out_l, out_r;

   // Candidate next position, reflections and exits; paddle overlap uses current positions.
   always_comb begin
      bx          = signed'({1'b0, x_reg});
      by          = signed'({1'b0, y_reg});
      pl          = signed'({1'b0, pad_l});
      pr          = signed'({1'b0, pad_r});
      nx          = vx_neg_reg ? bx - SPD : bx + SPD;
      ny          = vy_neg_reg ? by - SPD : by + SPD;
      ovl_l       = (by < pl + PH) && (by + SZ > pl);
      ovl_r       = (by < pr + PH) && (by + SZ > pr);
      hit_l       = vx_neg_reg && (nx <= L_FACE) && (nx + SZ > L_BACK) && ovl_l;
      hit_r       = !vx_neg_reg && (nx + SZ >= R_FACE) && (nx < R_BACK) && ovl_r;
      out_l       = vx_neg_reg && !hit_l && (nx <= 11'sd0);
      out_r       = !vx_neg_reg && !hit_r && (nx >= X_MAX);
      miss_l      = move && out_l;
      miss_r      = move && out_r;
      y_next      = ny[9:0];
      vy_neg_next = vy_neg_reg;
      if (ny <= 11'sd0) begin
         y_next      = 10'd0;
         vy_neg_next = 1'b0;
      end else if (ny >= Y_MAX) begin
         y_next      = 10'(Y_MAX);
         vy_neg_next = 1'b1;
      end
      x_next      = nx[9:0];
      vx_neg_next = vx_neg_reg;
      if (hit_l) begin
         x_next      = 10'(L_FACE);
         vx_neg_next = 1'b0;
      end else if (hit_r) begin
         x_next      = 10'(R_FACE - SZ);
         vx_neg_next = 1'b1;
      end
   end

   // Ball registers: recentre on serve, advance only on a move tick that is not a miss.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg      <= CX;
         y_reg      <= CY;
         vx_neg_reg <= 1'b0;
         vy_neg_reg <= 1'b0;
      end else if (centre) begin
         x_reg <= CX;
         y_reg <= CY;
      end else if (move && !out_l && !out_r) begin
         x_reg      <= x_next;
         y_reg      <= y_next;
         vx_neg_reg <= vx_neg_next;
         vy_neg_reg <= vy_neg_next;
      end
   end

   assign x = x_reg;
   assign y = y_reg;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game state, paddles, scoring and combinational pixel generation.
module pong_game_engine
   import pong_pkg::*;
#(
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_W     = 8,
   parameter int BALL_SZ      = 8,
   parameter int LEFT_X       = 16,
   parameter int RIGHT_X      = 616,
   parameter int PADDLE_SPEED = 4,
   parameter int BALL_SPEED   = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] xpix,
   input  logic [9:0] ypix,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   input  logic       start,
   output logic       pixval,
   output logic       altcolor,
   output logic       altcolor2,
   output logic [3:0] score_l,
   output logic [3:0] score_r
);

   localparam logic [9:0] PAD_INIT = 10'(V_ACTIVE / 2 - PADDLE_H / 2);
   localparam logic [9:0] NET_L    = 10'(H_ACTIVE / 2 - 2);
   localparam logic [9:0] NET_R    = 10'(H_ACTIVE / 2 + 1);

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == 4'hF) ? s : s + 4'd1;
   endfunction

   state_t           state_reg, state_next;
   logic [7:0]       cnt_reg, cnt_next;
   logic [3:0]       score_l_reg, score_l_next, score_r_reg, score_r_next;
   logic [1:0][9:0]  pad_reg, pad_next;
   logic [1:0]       up, dn, pad_hit;
   logic             tick, move, centre, miss_l, miss_r;
   logic [9:0]       ball_x, ball_y;
   logic [10:0]      xe, ye;
   logic             active, ball_hit, net_hit;

   assign tick = (xpix == 10'(TICK_X)) && (ypix == 10'(TICK_Y));
   assign up   = {btn_r_up, btn_l_up};
   assign dn   = {btn_r_dn, btn_l_dn};
   assign xe   = {1'b0, xpix};
   assign ye   = {1'b0, ypix};

   // Index 0 is the left paddle, index 1 the right one.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pad
         localparam int PX = (gi == 0) ? LEFT_X : RIGHT_X;
         assign pad_next[gi] = paddle_step(pad_reg[gi], up[gi], dn[gi], PADDLE_SPEED, PADDLE_H);
         assign pad_hit[gi]  = (xe >= 11'(PX)) && (xe < 11'(PX + PADDLE_W)) &&
                               (ye >= {1'b0, pad_reg[gi]}) &&
                               (ye < {1'b0, pad_reg[gi]} + 11'(PADDLE_H));
      end
   endgenerate

   assign move   = tick && (state_reg == ST_PLAY);
   assign centre = tick && (state_next == ST_SERVE) && (state_reg != ST_SERVE);

   pong_ball #(
      .PADDLE_H  (PADDLE_H),
      .PADDLE_W  (PADDLE_W),
      .BALL_SZ   (BALL_SZ),
      .LEFT_X    (LEFT_X),
      .RIGHT_X   (RIGHT_X),
      .BALL_SPEED(BALL_SPEED)
   ) u_ball (
      .clk   (clk),
      .rst   (rst),
      .move  (move),
      .centre(centre),
      .pad_l (pad_reg[0]),
      .pad_r (pad_reg[1]),
      .x     (ball_x),
      .y     (ball_y),
      .miss_l(miss_l),
      .miss_r(miss_r)
   );

   // Game state transitions as they would happen on the next tick.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      score_l_next = score_l_reg;
      score_r_next = score_r_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SERVE;
               cnt_next   = 8'd0;
            end
         end
         ST_SERVE: begin
            if (cnt_reg == 8'(SERVE_FRAMES - 1)) begin
               state_next = ST_PLAY;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         ST_PLAY: begin
            if (miss_r) begin
               score_l_next = sat_inc(score_l_reg);
               state_next   = ST_POINT;
               cnt_next     = 8'd0;
            end else if (miss_l) begin
               score_r_next = sat_inc(score_r_reg);
               state_next   = ST_POINT;
               cnt_next     = 8'd0;
            end
         end
         ST_POINT: begin
            if (cnt_reg == 8'(POINT_FRAMES - 1)) begin
               cnt_next   = 8'd0;
               state_next = ((score_l_reg == 4'(WIN_SCORE)) || (score_r_reg == 4'(WIN_SCORE)))
                            ? ST_OVER : ST_SERVE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         ST_OVER: begin
            if (start) begin
               score_l_next = 4'd0;
               score_r_next = 4'd0;
               state_next   = ST_SERVE;
               cnt_next     = 8'd0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Frame-stable registers load only on the frame tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 8'd0;
         score_l_reg <= 4'd0;
         score_r_reg <= 4'd0;
         pad_reg     <= {PAD_INIT, PAD_INIT};
      end else if (tick) begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         score_l_reg <= score_l_next;
         score_r_reg <= score_r_next;
         pad_reg     <= pad_next;
      end
   end

   // Pixel lookup against the frame-stable registers.
   always_comb begin
      active   = (xpix < 10'(H_ACTIVE)) && (ypix < 10'(V_ACTIVE));
      ball_hit = (xe >= {1'b0, ball_x}) && (xe < {1'b0, ball_x} + 11'(BALL_SZ)) &&
                 (ye >= {1'b0, ball_y}) && (ye < {1'b0, ball_y} + 11'(BALL_SZ));
      net_hit  = (xpix >= NET_L) && (xpix <= NET_R) && !ypix[3];
      pixval   = active && (ball_hit || (|pad_hit) || net_hit);
   end

   assign altcolor  = (state_reg == ST_POINT) && cnt_reg[2];
   assign altcolor2 = (state_reg == ST_SERVE) || (state_reg == ST_IDLE) || (state_reg == ST_OVER);
   assign score_l   = score_l_reg;
   assign score_r   = score_r_reg;

endmodule
